alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Sequential issue/execute controller sitting directly upstream of the 4-bit `alu`. It accepts commands over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU operand and select inputs from registered values, captures the ALU result and flags, and writes the result back to the register file.

## Interface
- `REG_NUM`, 4: register file depth; power of two, ≥2; `ADDR_W = $clog2(REG_NUM)`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 3: ALU select code, passed unchanged to `alu_select`.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in ADDR_W: destination and source register indices.
- `cmd_imm_en` in 1: operand B taken from `cmd_imm` instead of `rs2`.
- `cmd_imm` in 4: immediate operand.
- `ld_en` in 1: direct register-file write.
- `ld_addr` in ADDR_W: index for the direct write.
- `ld_data` in 4: data for the direct write.
- `alu_a`, `alu_b` out 4: ALU operands.
- `alu_select` out 3: ALU operation code.
- `alu_result` in 4: ALU result.
- `alu_overflow`, `alu_zero`, `alu_carry` in 1: ALU flags.
- `wb_valid` out 1: writeback beat.
- `wb_rd` out ADDR_W: writeback destination.
- `wb_data` out 4: writeback data.
- `flag_c`, `flag_z`, `flag_o` out 1: last captured ALU flags.
- `wb_ready` in 1: present only with `ALU_EXEC_WB_READY_EN`.

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `op`, `rd`, `opa=rf[rs1]`, `opb = imm_en ? imm : rf[rs2]`, then go to EXEC.
  - Without `cmd_valid`: stay in IDLE.
- EXEC:
  - `alu_a=opa`, `alu_b=opb`, `alu_select=op`; all are register outputs, stable for the whole cycle.
  - At the end of the cycle: `res_q<=alu_result`, `{flag_c,flag_z,flag_o}<={alu_carry,alu_zero,alu_overflow}`, then go to WB.
  - Flags are captured as-is for every op. The block does not reinterpret them.
- WB:
  - `wb_valid`=1, `wb_data=res_q`, `wb_rd=rd_q`.
  - On the handshake cycle, `rf[rd_q]<=res_q`, then go to IDLE.
  - Without the macro, the handshake cycle is the single WB cycle.
- `cmd_ready = rst_n && (state==IDLE)`. A command is never accepted while `rst_n`=0.
- Outside EXEC, `alu_a`/`alu_b`/`alu_select` keep their last latched values; no gating.
- Direct load: `ld_en` writes `rf[ld_addr]<=ld_data` in any state.
- Write collision: if the WB write and `ld_en` target the same index on the same edge, the WB write wins.
- Read timing: a command accepted on the same edge as a load reads the pre-edge register value.
- All arithmetic is 4-bit and width-exact. No sign or zero extension is performed in this block.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state IDLE; all `rf` entries 0; `opa`, `opb`, `op`, `rd_q`, `res_q` = 0.
  - flags 0; `wb_valid` 0; `alu_a`/`alu_b`/`alu_select` 0.
  - `cmd_ready` 0 while `rst_n` is low, 1 afterwards.
- Latency: command accepted at edge T → ALU inputs valid in cycle T+1 → `wb_valid` in cycle T+2 → register written at end of T+2.
- Throughput: one command per 3 cycles. The next acceptance occurs no earlier than the edge ending the WB cycle + 1 (IDLE cycle).
- Dependency: a command issued after writeback reads the updated register; no forwarding is needed.
- Reset mid-operation (EXEC or WB): abort, no register-file write, `wb_valid`=0 the next cycle.

## Configuration
- `ALU_EXEC_WB_READY_EN` defined:
  - Adds the `wb_ready` input.
  - WB holds until `wb_ready`=1; `wb_valid`/`wb_rd`/`wb_data` stay stable while stalled.
  - The register-file write and the return to IDLE occur on the edge where `wb_valid && wb_ready`.
- Undefined: no `wb_ready` port; WB lasts exactly one cycle.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release → `cmd_ready`=1, `wb_valid`=0, flags=000; an add of r0 and r1 into r2 writes back 0.
- Add with overflow: load r1=7, r2=1; command op=000, rd=3, rs1=1, rs2=2 accepted at T → cycle T+1 shows `alu_a`=7, `alu_b`=1, `alu_select`=000; cycle T+2 shows `wb_valid`=1, `wb_data`=8, `flag_o`=1, `flag_c`=0, `flag_z`=0; r3 then reads 8.
- Immediate subtract: r1=5, `cmd_imm_en`=1, imm=5, op=001 → `wb_data`=0, `flag_z`=1, `flag_c`=1, `flag_o`=0.
- Back-to-back dependency:
  - Hold `cmd_valid` with op=000 r2=r1+r1, followed by op=101 r3=r2^r1, where r1=3.
  - Second command accepted 3 cycles after the first and reads r2=6.
  - Second writeback `wb_data`=5.
- Collision and abort:
  - `ld_en` to r3 with 0xF on the WB edge of a write of 8 to r3 → r3=8.
  - `rst_n`=0 during EXEC → no `wb_valid`, r3 becomes 0.
- With `ALU_EXEC_WB_READY_EN`: `wb_ready`=0 for 3 cycles → `wb_valid` held with constant data, `cmd_ready`=0, register unchanged until the `wb_ready`=1 edge.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Command, register-load, ALU-side and writeback signals of alu_exec_ctrl.
// wb_ready is present only when ALU_EXEC_WB_READY_EN is defined.
interface alu_exec_ctrl_if #(
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic              cmd_imm_en;
  logic [3:0]        cmd_imm;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [3:0]        ld_data;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [2:0]        alu_select;
  logic [3:0]        alu_result;
  logic              alu_overflow;
  logic              alu_zero;
  logic              alu_carry;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [3:0]        wb_data;
  logic              flag_c;
  logic              flag_z;
  logic              flag_o;
`ifdef ALU_EXEC_WB_READY_EN
  logic              wb_ready;
`endif

  // Controller side
  modport slave (
`ifdef ALU_EXEC_WB_READY_EN
    input  wb_ready,
`endif
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
    input  ld_en, ld_addr, ld_data,
    input  alu_result, alu_overflow, alu_zero, alu_carry,
    output cmd_ready, alu_a, alu_b, alu_select,
    output wb_valid, wb_rd, wb_data, flag_c, flag_z, flag_o
  );

  // Environment side: command source, ALU and writeback sink
  modport master (
`ifdef ALU_EXEC_WB_READY_EN
    output wb_ready,
`endif
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
    output ld_en, ld_addr, ld_data,
    output alu_result, alu_overflow, alu_zero, alu_carry,
    input  cmd_ready, alu_a, alu_b, alu_select,
    input  wb_valid, wb_rd, wb_data, flag_c, flag_z, flag_o
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Issue/execute controller for the 4-bit ALU: IDLE -> EXEC -> WB with a small register file.
// Define ALU_EXEC_WB_READY_EN to let wb_ready stall the WB state.
module alu_exec_ctrl #(
  parameter int REG_NUM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_NUM);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state_q;
  logic [3:0]        rf_q [REG_NUM];
  logic [3:0]        opa_q, opb_q, res_q;
  logic [3:0]        opa_d, opb_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic              wb_valid_q;
  logic              flag_c_q, flag_z_q, flag_o_q;
  logic              wb_fire;

  assign opa_d = rf_q[bus.cmd_rs1];
  assign opb_d = bus.cmd_imm_en ? bus.cmd_imm : rf_q[bus.cmd_rs2];

`ifdef ALU_EXEC_WB_READY_EN
  assign wb_fire = (state_q == WB) && bus.wb_ready;
`else
  assign wb_fire = (state_q == WB);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      res_q      <= '0;
      wb_valid_q <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_o_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            rd_q    <= bus.cmd_rd;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q      <= bus.alu_result;
          flag_c_q   <= bus.alu_carry;
          flag_z_q   <= bus.alu_zero;
          flag_o_q   <= bus.alu_overflow;
          wb_valid_q <= 1'b1;
          state_q    <= WB;
        end
        WB: begin
          if (wb_fire) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Writeback has priority over a direct load to the same entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_NUM; i++) begin
      if (!rst_n)
        rf_q[i] <= '0;
      else if (wb_fire && (rd_q == ADDR_W'(i)))
        rf_q[i] <= res_q;
      else if (bus.ld_en && (bus.ld_addr == ADDR_W'(i)))
        rf_q[i] <= bus.ld_data;
    end
  end

  assign bus.cmd_ready  = rst_n && (state_q == IDLE);
  assign bus.alu_a      = opa_q;
  assign bus.alu_b      = opb_q;
  assign bus.alu_select = op_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = res_q;
  assign bus.flag_c     = flag_c_q;
  assign bus.flag_z     = flag_z_q;
  assign bus.flag_o     = flag_o_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small stand-in ALU (add, sub, xor).
// Define ALU_EXEC_WB_READY_EN to also exercise the writeback stall.
module tb_alu_exec_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_exec_ctrl_if #(.ADDR_W(2)) bus ();
  alu_exec_ctrl #(.REG_NUM(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stand-in ALU: carry is carry-out (no-borrow for subtract), overflow is signed
  logic [4:0] alu_sum;
  logic       alu_ovf;
  always_comb begin
    alu_sum = '0;
    alu_ovf = 1'b0;
    case (bus.alu_select)
      3'b000: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_ovf = (bus.alu_a[3] == bus.alu_b[3]) && (alu_sum[3] != bus.alu_a[3]);
      end
      3'b001: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
        alu_ovf = (bus.alu_a[3] != bus.alu_b[3]) && (alu_sum[3] != bus.alu_a[3]);
      end
      3'b101: alu_sum = {1'b0, bus.alu_a ^ bus.alu_b};
      default: alu_sum = '0;
    endcase
  end
  assign bus.alu_result   = alu_sum[3:0];
  assign bus.alu_carry    = alu_sum[4];
  assign bus.alu_overflow = alu_ovf;
  assign bus.alu_zero     = (alu_sum[3:0] == 4'd0);

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [3:0] ex_a, ex_b, wb_d;
  logic [2:0] ex_sel;
  logic [1:0] wb_r;
  logic       wb_v, fc, fz, fo, wb_rdy;

  task automatic load(input logic [1:0] addr, input logic [3:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    @(posedge clk); #1;
    bus.ld_en = 1'b0;
    $display("load r%0d <= %0h", addr, data);
  endtask

  // Starts in IDLE at #1 after an edge; ends in IDLE at #1 after an edge
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic imm_en, input logic [3:0] imm);
    bus.cmd_op     = op;
    bus.cmd_rd     = rd;
    bus.cmd_rs1    = rs1;
    bus.cmd_rs2    = rs2;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    bus.cmd_valid  = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_imm_en = 1'b0;
    ex_a = bus.alu_a; ex_b = bus.alu_b; ex_sel = bus.alu_select;
    @(posedge clk); #1;
    wb_v = bus.wb_valid; wb_d = bus.wb_data; wb_r = bus.wb_rd;
    fc = bus.flag_c; fz = bus.flag_z; fo = bus.flag_o; wb_rdy = bus.cmd_ready;
    @(posedge clk); #1;
    $display("cmd op=%0d rd=%0d rs1=%0d rs2=%0d imm_en=%0d imm=%0h -> a=%0h b=%0h wb_data=%0h czo=%0b%0b%0b",
             op, rd, rs1, rs2, imm_en, imm, ex_a, ex_b, wb_d, fc, fz, fo);
  endtask

  // Reads a register by adding immediate 0 into itself
  task automatic readback(input logic [1:0] r, output logic [3:0] v);
    run_cmd(3'b000, r, r, 2'd0, 1'b1, 4'd0);
    v = wb_d;
  endtask

  logic [3:0] rv;

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0;
    bus.cmd_rs2 = '0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
`ifdef ALU_EXEC_WB_READY_EN
    bus.wb_ready = 1'b1;
`endif

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready_low", bus.cmd_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_cmd_ready_high", bus.cmd_ready, 1'b1);
    check_eq("rst_wb_valid", bus.wb_valid, 1'b0);
    check_eq("rst_flags", {bus.flag_c, bus.flag_z, bus.flag_o}, 3'b000);
    check_eq("rst_alu_ins", {bus.alu_a, bus.alu_b, bus.alu_select}, 11'd0);
    @(posedge clk); #1;
    run_cmd(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0);
    check_eq("rst_add_wb_data", wb_d, 4'd0);
    check_eq("rst_add_wb_rd", wb_r, 2'd2);

    // Add with signed overflow: 7 + 1
    load(2'd1, 4'd7);
    load(2'd2, 4'd1);
    run_cmd(3'b000, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0);
    check_eq("add_alu_a", ex_a, 4'd7);
    check_eq("add_alu_b", ex_b, 4'd1);
    check_eq("add_alu_sel", ex_sel, 3'b000);
    check_eq("add_wb_valid", wb_v, 1'b1);
    check_eq("add_wb_data", wb_d, 4'd8);
    check_eq("add_wb_rd", wb_r, 2'd3);
    check_eq("add_flags_czo", {fc, fz, fo}, 3'b001);
    check_eq("add_cmd_ready_in_wb", wb_rdy, 1'b0);
    readback(2'd3, rv);
    check_eq("add_r3", rv, 4'd8);

    // Immediate subtract: 5 - 5
    load(2'd1, 4'd5);
    run_cmd(3'b001, 2'd2, 2'd1, 2'd3, 1'b1, 4'd5);
    check_eq("sub_alu_b_imm", ex_b, 4'd5);
    check_eq("sub_wb_data", wb_d, 4'd0);
    check_eq("sub_flags_czo", {fc, fz, fo}, 3'b110);

    // Back-to-back dependency with cmd_valid held
    load(2'd1, 4'd3);
    bus.cmd_op = 3'b000; bus.cmd_rd = 2'd2; bus.cmd_rs1 = 2'd1; bus.cmd_rs2 = 2'd1;
    bus.cmd_imm_en = 1'b0; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_op = 3'b101; bus.cmd_rd = 2'd3; bus.cmd_rs1 = 2'd2; bus.cmd_rs2 = 2'd1;
    check_eq("dep_exec_ready", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    check_eq("dep_wb1_data", bus.wb_data, 4'd6);
    check_eq("dep_wb1_ready", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    check_eq("dep_idle_ready", bus.cmd_ready, 1'b1);
    check_eq("dep_idle_wb_valid", bus.wb_valid, 1'b0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check_eq("dep_cmd2_alu_a", bus.alu_a, 4'd6);
    check_eq("dep_cmd2_alu_b", bus.alu_b, 4'd3);
    check_eq("dep_cmd2_sel", bus.alu_select, 3'b101);
    @(posedge clk); #1;
    check_eq("dep_wb2_data", bus.wb_data, 4'd5);
    check_eq("dep_wb2_rd", bus.wb_rd, 2'd3);
    $display("dep r2=r1+r1 then r3=r2^r1 -> %0h", bus.wb_data);
    @(posedge clk); #1;

    // Writeback vs. direct load collision on r3
    load(2'd1, 4'd7);
    bus.cmd_op = 3'b000; bus.cmd_rd = 2'd3; bus.cmd_rs1 = 2'd1;
    bus.cmd_imm_en = 1'b1; bus.cmd_imm = 4'd1; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_imm_en = 1'b0;
    @(posedge clk); #1;
    bus.ld_en = 1'b1; bus.ld_addr = 2'd3; bus.ld_data = 4'hF;
    @(posedge clk); #1;
    bus.ld_en = 1'b0;
    $display("collision wb r3<=8 vs ld r3<=F");
    readback(2'd3, rv);
    check_eq("collision_r3", rv, 4'd8);
    load(2'd0, 4'hF);
    readback(2'd0, rv);
    check_eq("load_r0", rv, 4'hF);

    // Reset during EXEC aborts the command and clears the register file
    bus.cmd_op = 3'b000; bus.cmd_rd = 2'd3; bus.cmd_rs1 = 2'd1;
    bus.cmd_imm_en = 1'b1; bus.cmd_imm = 4'd2; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_imm_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_wb_valid", bus.wb_valid, 1'b0);
    check_eq("abort_ready_in_rst", bus.cmd_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_wb_valid_after", bus.wb_valid, 1'b0);
    check_eq("abort_ready_after", bus.cmd_ready, 1'b1);
    $display("abort during exec");
    readback(2'd3, rv);
    check_eq("abort_r3", rv, 4'd0);

`ifdef ALU_EXEC_WB_READY_EN
    // Writeback stall for 3 cycles
    load(2'd1, 4'd9);
    bus.wb_ready = 1'b0;
    bus.cmd_op = 3'b000; bus.cmd_rd = 2'd2; bus.cmd_rs1 = 2'd1;
    bus.cmd_imm_en = 1'b1; bus.cmd_imm = 4'd0; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_imm_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("stall_wb_valid", bus.wb_valid, 1'b1);
      check_eq("stall_wb_data", bus.wb_data, 4'd9);
      check_eq("stall_wb_rd", bus.wb_rd, 2'd2);
      check_eq("stall_cmd_ready", bus.cmd_ready, 1'b0);
    end
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("stall_release_wb_valid", bus.wb_valid, 1'b0);
    check_eq("stall_release_ready", bus.cmd_ready, 1'b1);
    $display("stall 3 cycles wb_data=9");
    readback(2'd2, rv);
    check_eq("stall_r2", rv, 4'd9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
